dsp48a1_mac_ctrl: RTL and testbench
===================================

Name: dsp48a1_mac_ctrl

Overview:
Initiator-side sequencer that drives a DSP48A1 slice as a signed multiply-accumulate engine for streamed operand vectors.
- Accepts (A,B) pairs over a valid/ready stream.
- Drives the slice's A, B, OPMODE, CE and reset pins, and tracks the slice pipeline latency.
- Captures P when the last product has accumulated and presents one 48-bit dot-product per vector on a valid/ready output.
- Sits between the upstream sample source and the DSP48A1 instance.

Parameters:
MUL_LAT, 2, cycles from operands on DSP_A/DSP_B to the product at the post-adder input (A/B reg + M reg); the DSP instance is built with this latency and OPMODEREG=0.
MAX_LEN, 1024, maximum beats per vector; must be ≥1 and ≤4096.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  operand beat valid
IN_READY  out  1  controller accepts a beat this cycle
IN_A  in  18  signed operand A
IN_B  in  18  signed operand B
IN_LAST  in  1  beat is the last of its vector
OUT_VALID  out  1  result valid
OUT_READY  in  1  downstream accepts the result
OUT_P  out  48  signed accumulated result
OUT_LEN  out  13  beats accumulated into OUT_P
OUT_TRUNC  out  1  vector was cut at MAX_LEN
DSP_A  out  18  to slice A
DSP_B  out  18  to slice B
DSP_OPMODE  out  8  to slice OPMODE
DSP_CE  out  1  common clock enable to all slice CE pins
DSP_RST  out  1  common reset to all slice RST pins
DSP_P  in  48  from slice P

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State→IDLE; tag/opmode delay lines cleared; beat counter 0.
  - OUT_VALID=0, OUT_P=0, OUT_LEN=0, OUT_TRUNC=0, IN_READY=0.
  - DSP_A=0, DSP_B=0, DSP_OPMODE=0, DSP_CE=1.
  - DSP_RST=RST, combinational pass-through, so the slice resets in the same cycle.
  - Applies identically mid-vector; the partial sum is discarded and no result is emitted.
- Accepted beat = IN_VALID & IN_READY.
  - Registered next cycle onto DSP_A/DSP_B.
  - Non-accepted cycles in ACCUM/DRAIN issue DSP_A=DSP_B=0 (bubble; adds 0).
- OPMODE per issued beat:
  - First beat of a vector: 8'h01 (X=M, Z=0, no pre-adder, add).
  - All later beats and bubbles: 8'h09 (X=M, Z=P, accumulate).
  - Driven through an internal MUL_LAT-stage delay line so it reaches DSP_OPMODE in the same cycle the matching product reaches the post-adder.
- Tag pipeline (MUL_LAT+1 stages) carries {valid, last} alongside each issued beat.
  - When a last-tag exits, DSP_P holds the final sum.
  - Controller registers DSP_P→OUT_P and sets OUT_VALID on the next edge.
  - Latency: last beat accepted at edge t → OUT_VALID high after edge t+MUL_LAT+3.
- FSM:
  - IDLE: IN_READY=1. Accepted beat → ACCUM, or → DRAIN if IN_LAST.
  - ACCUM: IN_READY=1; counter increments per beat. Accepted beat with IN_LAST, or counter reaching MAX_LEN → DRAIN.
  - DRAIN: IN_READY=0; wait for the last-tag to exit, capture, → HOLD.
  - HOLD: OUT_VALID=1; OUT_P/OUT_LEN/OUT_TRUNC stable until OUT_VALID & OUT_READY → IDLE.
- Only one vector is in flight: no beats are accepted from DRAIN until result handoff.
- Truncation:
  - The MAX_LEN-th beat is treated as last and sets OUT_TRUNC=1.
  - Further upstream beats of the same vector start a new vector.
  - A beat with IN_LAST exactly at MAX_LEN gives OUT_TRUNC=0.
- Arithmetic:
  - Products are signed 18×18→36, sign-extended to 48 by the slice.
  - Accumulation wraps modulo 2^48 with no saturation.
- OUT_LEN = number of accepted beats (1..MAX_LEN).

Test Plan:
1. Reset, then beats (20,10),(5,6,LAST) back-to-back → OUT_P=48'd230, OUT_LEN=2, OUT_TRUNC=0; OUT_VALID rises exactly MUL_LAT+3 edges after the LAST beat is accepted.
2. Single beat (-3,7,LAST) → OUT_P=48'hFFFF_FFFF_FFEB, OUT_LEN=1; DSP_OPMODE=8'h01 on that beat's post-adder cycle.
3. Beats (100,100),(2,3,LAST) with 3 idle cycles between them → OUT_P=48'd10006; bubbles observed as DSP_A=DSP_B=0, DSP_OPMODE=8'h09.
4. OUT_READY held low 5 cycles in HOLD → OUT_VALID and OUT_P stay constant and IN_READY=0 throughout; next vector accepted the cycle after handoff.
5. MAX_LEN=4, six beats of (1,1) with LAST on the 6th → results OUT_P=4, OUT_LEN=4, OUT_TRUNC=1, then OUT_P=2, OUT_LEN=2, OUT_TRUNC=0.
6. RST pulsed one cycle after the 2nd of 3 beats → DSP_RST=1 that cycle, OUT_VALID never asserts, FSM in IDLE; a following vector (4,4,LAST) yields OUT_P=16.

Source files
------------

// File: rtl/dsp48a1_mac_ctrl.sv
// dsp48a1_mac_ctrl: streams signed operand pairs into a DSP48A1 slice and returns one 48-bit dot-product per vector.
module dsp48a1_mac_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int MAX_LEN = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    input  logic        IN_LAST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [47:0] OUT_P,
    output logic [12:0] OUT_LEN,
    output logic        OUT_TRUNC,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CE,
    output logic        DSP_RST,
    input  logic [47:0] DSP_P
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d, beat_n;
    logic [17:0] a_q, b_q;
    logic [1:0]  tag_q [0:MUL_LAT];
    logic [7:0]  opm_q [0:MUL_LAT];
    logic [1:0]  ext_q;
    logic [47:0] p_q, out_p_q;
    logic [12:0] out_len_q;
    logic        trunc_q, out_trunc_q, acc, full, done;

    assign IN_READY   = !RST && (state_q == IDLE || state_q == ACCUM);
    assign acc        = IN_VALID && IN_READY;
    assign beat_n     = state_q == IDLE ? 13'd1 : cnt_q + 13'd1;
    assign full       = beat_n == 13'(MAX_LEN);
    assign done       = IN_LAST || full;
    assign OUT_VALID  = state_q == HOLD;
    assign OUT_P      = out_p_q;
    assign OUT_LEN    = out_len_q;
    assign OUT_TRUNC  = out_trunc_q;
    assign DSP_A      = a_q;
    assign DSP_B      = b_q;
    assign DSP_OPMODE = opm_q[MUL_LAT];
    assign DSP_CE     = 1'b1;
    assign DSP_RST    = RST;

    always_comb begin
        cnt_d   = acc ? beat_n : cnt_q;
        state_d = acc ? (done ? DRAIN : ACCUM)
                : (state_q == DRAIN && ext_q[1]) ? HOLD
                : (state_q == HOLD && OUT_READY) ? IDLE
                : state_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= '0;
                opm_q[i] <= '0;
            end
            ext_q       <= '0;
            p_q         <= '0;
            trunc_q     <= 1'b0;
            out_p_q     <= '0;
            out_len_q   <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= acc ? IN_A : 18'd0;
            b_q      <= acc ? IN_B : 18'd0;
            tag_q[0] <= {acc, acc && done};
            opm_q[0] <= (acc && state_q == IDLE) ? 8'h01 : 8'h09;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
                opm_q[i] <= opm_q[i-1];
            end
            // ext_q[0]: last product has entered P; ext_q[1] lines up with the registered copy of P
            ext_q    <= {ext_q[0], tag_q[MUL_LAT] == 2'b11};
            p_q      <= DSP_P;
            if (acc && done)
                trunc_q <= !IN_LAST;
            if (state_q == DRAIN && ext_q[1]) begin
                out_p_q     <= p_q;
                out_len_q   <= cnt_q;
                out_trunc_q <= trunc_q;
            end
        end
    end
endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb_dsp48a1_mac_ctrl: directed vectors against the controller driving a behavioural DSP48A1 (A1/B1, M, P regs).
module tb_dsp48a1_mac_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_trunc;
    logic        dsp_ce, dsp_rst;
    logic [17:0] in_a, in_b, dsp_a, dsp_b;
    logic [47:0] out_p, dsp_p;
    logic [12:0] out_len;
    logic [7:0]  dsp_opmode;
    int          n_vec = 0, n_err = 0, lat;

    always #5 clk = ~clk;

    dsp48a1_mac_ctrl #(.MUL_LAT(2), .MAX_LEN(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_B(in_b),
        .IN_LAST(in_last), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_P(out_p),
        .OUT_LEN(out_len), .OUT_TRUNC(out_trunc), .DSP_A(dsp_a), .DSP_B(dsp_b),
        .DSP_OPMODE(dsp_opmode), .DSP_CE(dsp_ce), .DSP_RST(dsp_rst), .DSP_P(dsp_p)
    );

    logic [17:0]        a1, b1;
    logic signed [47:0] m_r;
    logic [47:0]        p_r;
    assign dsp_p = p_r;
    always_ff @(posedge clk) begin
        if (dsp_rst) begin
            a1  <= '0;
            b1  <= '0;
            m_r <= '0;
            p_r <= '0;
        end else if (dsp_ce) begin
            a1  <= dsp_a;
            b1  <= dsp_b;
            m_r <= $signed(a1) * $signed(b1);
            p_r <= (dsp_opmode[3:2] == 2'b10 ? p_r : 48'd0) + (dsp_opmode[1:0] == 2'b01 ? m_r : 48'd0);
        end
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
        int w = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) chk("send_ready", 48'(in_ready), 48'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic get_res(input string tag, input logic [47:0] p, input logic [12:0] len,
                           input logic tr, output int n);
        wait_valid(n);
        chk({tag, "_valid"}, 48'(out_valid), 48'd1);
        chk({tag, "_p"}, out_p, p);
        chk({tag, "_len"}, 48'(out_len), 48'(len));
        chk({tag, "_trunc"}, 48'(out_trunc), 48'(tr));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 48'(out_valid), 48'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_dsp_rst", 48'(dsp_rst), 48'd1);
        chk("rst_in_ready", 48'(in_ready), 48'd0);
        chk("rst_ce", 48'(dsp_ce), 48'd1);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_out_p", out_p, 48'd0);
        chk("rst_out_len", 48'(out_len), 48'd0);
        chk("rst_out_trunc", 48'(out_trunc), 48'd0);
        chk("rst_dsp_a", 48'(dsp_a), 48'd0);
        chk("rst_dsp_b", 48'(dsp_b), 48'd0);
        chk("rst_opmode", 48'(dsp_opmode), 48'd0);
        rst = 1'b0;
        #1;
        chk("rst_release", 48'(dsp_rst), 48'd0);
        chk("idle_ready", 48'(in_ready), 48'd1);

        send(18'd20, 18'd10, 1'b0);
        send(18'd5, 18'd6, 1'b1);
        get_res("t1", 48'd230, 13'd2, 1'b0, lat);
        chk("t1_latency", 48'(lat), 48'd5);

        send(-18'sd3, 18'd7, 1'b1);
        tick();
        tick();
        chk("t2_opmode_first", 48'(dsp_opmode), 48'h01);
        get_res("t2", 48'hFFFF_FFFF_FFEB, 13'd1, 1'b0, lat);
        chk("t2_latency", 48'(lat), 48'd3);

        send(18'd100, 18'd100, 1'b0);
        chk("t3_issue_a", 48'(dsp_a), 48'd100);
        tick();
        chk("t3_bubble_a", 48'(dsp_a), 48'd0);
        chk("t3_bubble_b", 48'(dsp_b), 48'd0);
        tick();
        chk("t3_opmode_first", 48'(dsp_opmode), 48'h01);
        tick();
        chk("t3_opmode_bubble", 48'(dsp_opmode), 48'h09);
        send(18'd2, 18'd3, 1'b1);
        get_res("t3", 48'd10006, 13'd2, 1'b0, lat);

        send(18'd7, 18'd8, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 48'(out_valid), 48'd1);
            chk("t4_hold_p", out_p, 48'd56);
            chk("t4_hold_ready", 48'(in_ready), 48'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_handoff_valid", 48'(out_valid), 48'd0);
        chk("t4_handoff_ready", 48'(in_ready), 48'd1);
        send(18'd9, -18'sd2, 1'b1);
        chk("t4_next_accepted", 48'(in_ready), 48'd0);
        get_res("t4", 48'hFFFF_FFFF_FFEE, 13'd1, 1'b0, lat);

        for (int i = 0; i < 4; i++) send(18'd1, 18'd1, 1'b0);
        chk("t5_cut_ready", 48'(in_ready), 48'd0);
        get_res("t5a", 48'd4, 13'd4, 1'b1, lat);
        send(18'd1, 18'd1, 1'b0);
        send(18'd1, 18'd1, 1'b1);
        get_res("t5b", 48'd2, 13'd2, 1'b0, lat);
        for (int i = 0; i < 4; i++) send(18'd3, 18'd1, i == 3);
        get_res("t5c", 48'd12, 13'd4, 1'b0, lat);

        send(18'd1, 18'd2, 1'b0);
        send(18'd3, 18'd4, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_a = 18'd5; in_b = 18'd6; in_last = 1'b1;
        #1;
        chk("t6_dsp_rst", 48'(dsp_rst), 48'd1);
        chk("t6_rst_ready", 48'(in_ready), 48'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("t6_idle", 48'(in_ready), 48'd1);
        chk("t6_opmode_clr", 48'(dsp_opmode), 48'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | int'(out_valid);
        end
        chk("t6_no_result", 48'(seen), 48'd0);
        send(18'd4, 18'd4, 1'b1);
        get_res("t6", 48'd16, 13'd1, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
